// File: rtl/gc_pkg.sv
// Shared definitions for the global controller: configuration select ids,
// sequencer state encoding and the configuration beat arithmetic.
package gc_pkg;

    localparam logic [2:0] SEL_ITER_SEQ = 3'b010;
    localparam logic [2:0] SEL_STRIDE   = 3'b011;

    typedef enum logic [1:0] {
        CONF = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // Number of conf_bus beats needed to load one iteration variable.
    function automatic int beats_per_value(input int var_width, input int bus_width);
        return var_width / bus_width;
    endfunction

endpackage

// File: rtl/ripple_bound_encoder.sv
// Ripple comparison of the iteration vector against the bounds: selects the
// lowest dimension not yet at its bound, or flags the last iteration.
module ripple_bound_encoder #(
    parameter int DIMENSION                = 3,
    parameter int ITERATION_VARIABLE_WIDTH = 16
) (
    input  logic [0:DIMENSION*ITERATION_VARIABLE_WIDTH-1] x_vec,
    input  logic [0:DIMENSION*ITERATION_VARIABLE_WIDTH-1] bound_vec,
    output logic [0:DIMENSION-1]                          stride_select,
    output logic                                          iter_last
);
    localparam int W = ITERATION_VARIABLE_WIDTH;

    logic [DIMENSION-1:0] at_bound;
    // lower_done[d]: every dimension below d sits at its bound
    logic [DIMENSION:0]   lower_done;

    assign lower_done[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIMENSION; gi++) begin : g_ripple
            assign at_bound[gi]       = (x_vec[gi*W +: W] == bound_vec[gi*W +: W]);
            assign stride_select[gi]  = lower_done[gi] & ~at_bound[gi];
            assign lower_done[gi+1]   = lower_done[gi] & at_bound[gi];
        end
    endgenerate

    assign iter_last = lower_done[DIMENSION];

endmodule

// File: rtl/iteration_sequencer_ripple.sv
// Iteration sequencer: loads start/bound vectors over conf_bus, then walks the
// rectangular iteration space by latching ivar_next from the stride selector.
module iteration_sequencer_ripple
    import gc_pkg::*;
#(
    parameter int DIMENSION                = 3,
    parameter int ITERATION_VARIABLE_WIDTH = 16,
    parameter int MATRIX_ELEMENT_WIDTH     = 8,
    parameter int SELECT_WIDTH             = 3
) (
    input  logic                                          conf_clk,
    input  logic                                          reset,
    input  logic [MATRIX_ELEMENT_WIDTH-1:0]               conf_bus,
    input  logic [SELECT_WIDTH-1:0]                       sel,
    input  logic                                          start,
    input  logic                                          step_en,
    input  logic [0:DIMENSION*ITERATION_VARIABLE_WIDTH-1] ivar_next,
    output logic [0:DIMENSION*ITERATION_VARIABLE_WIDTH-1] x_bus,
    output logic [0:DIMENSION-1]                          stride_select,
    output logic                                          iter_valid,
    output logic                                          iter_last,
    output logic                                          done,
    output logic                                          conf_ack,
    output logic                                          busy
);
    localparam int W     = ITERATION_VARIABLE_WIDTH;
    localparam int M     = MATRIX_ELEMENT_WIDTH;
    localparam int VW    = DIMENSION * W;
    localparam int BEATS = beats_per_value(W, M);
    localparam int CCW   = $clog2(BEATS + 1);
    localparam int VCW   = $clog2(2 * DIMENSION + 1);

    seq_state_t           state_reg, state_next;
    logic [W-1:0]         start_reg [DIMENSION];
    logic [W-1:0]         bound_reg [DIMENSION];
    logic [0:VW-1]        start_vec, bound_vec;
    logic [0:VW-1]        x_reg, x_next;
    logic [CCW-1:0]       chunk_cnt_reg;
    logic [VCW-1:0]       value_cnt_reg;
    logic                 conf_ack_reg;
    logic                 beat_take, final_beat;
    logic [0:DIMENSION-1] enc_select;
    logic                 enc_last;

    generate
        for (genvar gi = 0; gi < DIMENSION; gi++) begin : g_pack
            assign start_vec[gi*W +: W] = start_reg[gi];
            assign bound_vec[gi*W +: W] = bound_reg[gi];
        end
    endgenerate

    ripple_bound_encoder #(
        .DIMENSION               (DIMENSION),
        .ITERATION_VARIABLE_WIDTH(W)
    ) u_encoder (
        .x_vec        (x_reg),
        .bound_vec    (bound_vec),
        .stride_select(enc_select),
        .iter_last    (enc_last)
    );

    assign beat_take  = (state_reg == CONF) && (sel == SEL_ITER_SEQ) && !conf_ack_reg;
    assign final_beat = beat_take && (value_cnt_reg == VCW'(2*DIMENSION-1))
                        && (chunk_cnt_reg == CCW'(BEATS-1));

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        unique case (state_reg)
            CONF: if (final_beat) begin
                state_next = IDLE;
                x_next     = start_vec;
            end
            IDLE: if (start) state_next = RUN;
            RUN: if (step_en) begin
                if (enc_last) begin
                    state_next = DONE;
                    x_next     = start_vec;
                end else begin
                    x_next     = ivar_next;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = CONF;
        endcase
    end

    always_ff @(posedge conf_clk) begin
        if (reset) begin
            state_reg     <= CONF;
            x_reg         <= '0;
            chunk_cnt_reg <= '0;
            value_cnt_reg <= '0;
            conf_ack_reg  <= 1'b0;
            for (int d = 0; d < DIMENSION; d++) begin
                start_reg[d] <= '0;
                bound_reg[d] <= '0;
            end
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            if (final_beat) conf_ack_reg <= 1'b1;
            if (beat_take) begin
                // Chunks arrive least-significant first; values start[] then bound[]
                for (int d = 0; d < DIMENSION; d++) begin
                    for (int c = 0; c < BEATS; c++) begin
                        if (chunk_cnt_reg == CCW'(c)) begin
                            if (value_cnt_reg == VCW'(d))
                                start_reg[d][c*M +: M] <= conf_bus;
                            if (value_cnt_reg == VCW'(DIMENSION + d))
                                bound_reg[d][c*M +: M] <= conf_bus;
                        end
                    end
                end
                if (chunk_cnt_reg == CCW'(BEATS-1)) begin
                    chunk_cnt_reg <= '0;
                    value_cnt_reg <= value_cnt_reg + VCW'(1);
                end else begin
                    chunk_cnt_reg <= chunk_cnt_reg + CCW'(1);
                end
            end
        end
    end

    assign x_bus         = x_reg;
    assign iter_valid    = (state_reg == RUN);
    assign busy          = (state_reg == RUN);
    assign done          = (state_reg == DONE);
    assign conf_ack      = conf_ack_reg;
    assign stride_select = (state_reg == RUN) ? enc_select : '0;
    assign iter_last     = (state_reg == RUN) && enc_last;

endmodule

// File: tb/tb_iteration_sequencer_ripple.sv
// Directed bench for iteration_sequencer_ripple with a behavioural stride selector.
module tb_iteration_sequencer_ripple;
    localparam int D = 3;
    localparam int W = 16;
    localparam int M = 8;

    logic            conf_clk = 1'b0;
    logic            reset;
    logic [M-1:0]    conf_bus;
    logic [2:0]      sel;
    logic            start;
    logic            step_en;
    logic [0:D*W-1]  ivar_next;
    logic [0:D*W-1]  x_bus;
    logic [0:D-1]    stride_select;
    logic            iter_valid, iter_last, done, conf_ack, busy;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    always #5 conf_clk = ~conf_clk;

    iteration_sequencer_ripple #(
        .DIMENSION(D), .ITERATION_VARIABLE_WIDTH(W),
        .MATRIX_ELEMENT_WIDTH(M), .SELECT_WIDTH(3)
    ) dut (
        .conf_clk(conf_clk), .reset(reset), .conf_bus(conf_bus), .sel(sel),
        .start(start), .step_en(step_en), .ivar_next(ivar_next),
        .x_bus(x_bus), .stride_select(stride_select), .iter_valid(iter_valid),
        .iter_last(iter_last), .done(done), .conf_ack(conf_ack), .busy(busy)
    );

    function automatic logic [D*W-1:0] pk(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        return {a, b, c};
    endfunction

    // Stride selector model: col0 = dim0+1; col1 = dim0 reset, dim1+1; col2 = dims0,1 reset, dim2+1
    always_comb begin
        ivar_next = x_bus;
        if (stride_select[0])
            ivar_next = pk(x_bus[0 +: W] + 16'd1, x_bus[W +: W], x_bus[2*W +: W]);
        else if (stride_select[1])
            ivar_next = pk(16'd0, x_bus[W +: W] + 16'd1, x_bus[2*W +: W]);
        else if (stride_select[2])
            ivar_next = pk(16'd0, 16'd0, x_bus[2*W +: W] + 16'd1);
    end

    task automatic tick();
        @(posedge conf_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic configure(input logic [W-1:0] s0, input logic [W-1:0] s1,
                             input logic [W-1:0] s2, input logic [W-1:0] b0,
                             input logic [W-1:0] b1, input logic [W-1:0] b2,
                             input bit interleave);
        logic [W-1:0] vals [6];
        vals = '{s0, s1, s2, b0, b1, b2};
        for (int v = 0; v < 6; v++) begin
            for (int c = 0; c < W/M; c++) begin
                sel      = 3'b010;
                conf_bus = vals[v][c*M +: M];
                tick();
                check("conf_ack_after_beat", {63'd0, conf_ack},
                      {63'd0, (v == 5 && c == W/M-1)});
                if (interleave) begin
                    sel      = 3'b011;
                    conf_bus = M'($urandom);
                    tick();
                end
            end
        end
        sel      = 3'b000;
        conf_bus = '0;
        $display("config start=(%0d,%0d,%0d) bound=(%0d,%0d,%0d)", s0, s1, s2, b0, b1, b2);
    endtask

    task automatic begin_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_busy", {63'd0, busy}, 64'd1);
        check("run_iter_valid", {63'd0, iter_valid}, 64'd1);
    endtask

    logic [D*W-1:0] exp_x   [6];
    logic [D-1:0]   exp_sel [6];

    initial begin
        exp_x   = '{pk(0,0,0), pk(1,0,0), pk(2,0,0), pk(0,1,0), pk(1,1,0), pk(2,1,0)};
        exp_sel = '{3'b100, 3'b100, 3'b010, 3'b100, 3'b100, 3'b000};
        reset = 1'b1; conf_bus = '0; sel = '0; start = 1'b0; step_en = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_conf_ack", {63'd0, conf_ack}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_iter_valid", {63'd0, iter_valid}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_x_bus", 64'(x_bus), 64'd0);

        // Interleaved foreign-select beats must not disturb the stored values
        configure(0, 0, 0, 2, 1, 0, 1'b1);
        check("conf_x_bus", 64'(x_bus), 64'(pk(0,0,0)));
        for (int i = 0; i < 3; i++) begin
            sel = 3'b010; conf_bus = 8'hFF; tick();
        end
        sel = 3'b000;
        check("idle_stride_select", 64'(stride_select), 64'd0);
        check("idle_iter_valid", {63'd0, iter_valid}, 64'd0);

        // Full run, step_en held high
        begin_run();
        step_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("walk_x_bus", 64'(x_bus), 64'(exp_x[i]));
            check("walk_stride_select", 64'(stride_select), 64'(exp_sel[i]));
            check("walk_iter_last", {63'd0, iter_last}, {63'd0, i == 5});
            check("walk_done_low", {63'd0, done}, 64'd0);
            $display("step %0d x_bus=%h stride_select=%b", i, x_bus, stride_select);
            tick();
        end
        step_en = 1'b0;
        check("walk_done", {63'd0, done}, 64'd1);
        check("walk_done_busy", {63'd0, busy}, 64'd0);
        check("walk_done_valid", {63'd0, iter_valid}, 64'd0);
        check("walk_done_x_bus", 64'(x_bus), 64'(pk(0,0,0)));
        tick();
        check("walk_done_pulse", {63'd0, done}, 64'd0);
        check("walk_back_idle", {63'd0, busy}, 64'd0);

        // Stalled run: step_en alternating 0/1
        begin_run();
        for (int i = 0; i < 6; i++) begin
            step_en = 1'b0;
            check("stall_x_bus", 64'(x_bus), 64'(exp_x[i]));
            tick();
            check("stall_x_hold", 64'(x_bus), 64'(exp_x[i]));
            check("stall_done_low", {63'd0, done}, 64'd0);
            step_en = 1'b1;
            tick();
        end
        step_en = 1'b0;
        check("stall_done", {63'd0, done}, 64'd1);
        tick();

        // Reset mid-run at (1,1,0)
        begin_run();
        step_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        step_en = 1'b0;
        check("abort_pre_x", 64'(x_bus), 64'(pk(1,1,0)));
        reset = 1'b1;
        tick();
        check("abort_conf_ack", {63'd0, conf_ack}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_x_bus", 64'(x_bus), 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        tick();
        check("abort_done_after", {63'd0, done}, 64'd0);
        check("abort_still_conf", {63'd0, conf_ack}, 64'd0);

        // Degenerate start == bound
        configure(5, 5, 5, 5, 5, 5, 1'b0);
        check("degen_idle_x", 64'(x_bus), 64'(pk(5,5,5)));
        begin_run();
        check("degen_iter_last", {63'd0, iter_last}, 64'd1);
        check("degen_stride_select", 64'(stride_select), 64'd0);
        step_en = 1'b1;
        tick();
        step_en = 1'b0;
        check("degen_done", {63'd0, done}, 64'd1);
        check("degen_x_bus", 64'(x_bus), 64'(pk(5,5,5)));
        tick();
        check("degen_done_pulse", {63'd0, done}, 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
